// File: rtl/ife_stat.sv
// Post-filter statistics engine: scans the 2^AW-pixel result image once through a
// synchronous-read RAM port and builds a 16-bin histogram plus min, max, sum and mean.
module ife_stat #(
   parameter int AW = 14,
   parameter int DW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     raddr,
   input  logic [DW-1:0]     rdata,
   input  logic [3:0]        bin_sel,
   output logic [AW:0]       bin_cnt,
   output logic [DW-1:0]     min_val,
   output logic [DW-1:0]     max_val,
   output logic [AW+DW-1:0]  sum_val,
   output logic [DW-1:0]     mean_val
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = '1;

   state_t              state_q, state_d;
   logic [AW-1:0]       raddr_q, raddr_d;
   logic [AW:0]         bin_q [16];
   logic [AW:0]         bin_d [16];
   logic [AW+DW-1:0]    sum_q, sum_d;
   logic [DW-1:0]       min_q, min_d;
   logic [DW-1:0]       max_q, max_d;
   logic                clear;
   logic                acc;
   logic [3:0]          pix_bin;

   assign pix_bin = rdata[DW-1 -: 4];

   // FSM: decides when to clear, when the RAM data is a valid pixel, and the next address
   always_comb begin
      state_d = state_q;
      raddr_d = raddr_q;
      clear   = 1'b0;
      acc     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               clear   = 1'b1;
               raddr_d = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            // First READ cycle has no returned data yet (address 0 only just issued)
            acc = (raddr_q != '0);
            if (raddr_q == LAST_ADDR) begin
               state_d = S_DRAIN;
            end else begin
               raddr_d = raddr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            acc     = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      sum_d = sum_q;
      min_d = min_q;
      max_d = max_q;
      for (int i = 0; i < 16; i++) begin
         bin_d[i] = bin_q[i];
      end
      if (clear) begin
         sum_d = '0;
         min_d = '1;
         max_d = '0;
         for (int i = 0; i < 16; i++) begin
            bin_d[i] = '0;
         end
      end else if (acc) begin
         sum_d = sum_q + {{AW{1'b0}}, rdata};
         if (rdata < min_q) min_d = rdata;
         if (rdata > max_q) max_d = rdata;
         for (int i = 0; i < 16; i++) begin
            if (pix_bin == 4'(i)) begin
               bin_d[i] = bin_q[i] + (AW+1)'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         raddr_q <= '0;
         sum_q   <= '0;
         min_q   <= '1;
         max_q   <= '0;
         for (int i = 0; i < 16; i++) begin
            bin_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         sum_q   <= sum_d;
         min_q   <= min_d;
         max_q   <= max_d;
         for (int i = 0; i < 16; i++) begin
            bin_q[i] <= bin_d[i];
         end
      end
   end

   assign busy     = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);
   assign raddr    = raddr_q;
   assign bin_cnt  = bin_q[bin_sel];
   assign min_val  = min_q;
   assign max_val  = max_q;
   assign sum_val  = sum_q;
   assign mean_val = sum_q[AW+DW-1:AW];

endmodule

// File: tb/tb_ife_stat.sv
// Directed bench for ife_stat: a behavioural synchronous RAM feeds fixed images and
// the resulting statistics are compared against hand-computed constants.
module tb_ife_stat;

   localparam int AW = 14;
   localparam int DW = 8;
   localparam int NPIX = 1 << AW;

   logic              clk;
   logic              reset;
   logic              start;
   logic              busy;
   logic              done;
   logic [AW-1:0]     raddr;
   logic [DW-1:0]     rdata;
   logic [3:0]        bin_sel;
   logic [AW:0]       bin_cnt;
   logic [DW-1:0]     min_val;
   logic [DW-1:0]     max_val;
   logic [AW+DW-1:0]  sum_val;
   logic [DW-1:0]     mean_val;

   logic [DW-1:0]     mem [NPIX];

   int n_cmp;
   int n_bad;
   int gap_err;

   ife_stat #(.AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .raddr    (raddr),
      .rdata    (rdata),
      .bin_sel  (bin_sel),
      .bin_cnt  (bin_cnt),
      .min_val  (min_val),
      .max_val  (max_val),
      .sum_val  (sum_val),
      .mean_val (mean_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read result RAM
   always @(posedge clk) rdata <= mem[raddr];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // mode 0: constant val, 1: ramp k[7:0], 2: first half 8'h23 / second half 8'hC7
   task automatic fill(input int mode, input logic [7:0] val);
      for (int k = 0; k < NPIX; k++) begin
         case (mode)
            0: mem[k] = val;
            1: mem[k] = 8'(k);
            default: mem[k] = (k < NPIX / 2) ? 8'h23 : 8'hC7;
         endcase
      end
   endtask

   // Pulses start, then follows the scan cycle by cycle (cycle 1 = first cycle after the
   // edge that samples start), optionally re-pulsing start in cycles p1/p2.
   task automatic scan(input int p1, input int p2, output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      bcnt  = 0;
      while (!done && lat < 20000) begin
         if (busy) bcnt++;
         if (raddr != AW'((lat <= NPIX) ? lat - 1 : NPIX - 1)) gap_err++;
         start = (lat == p1) || (lat == p2);
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic chk_bins(input string tag, input int hot_a, input int cnt_a,
                           input int hot_b, input int cnt_b);
      for (int i = 0; i < 16; i++) begin
         bin_sel = 4'(i);
         #1;
         chk($sformatf("%s_bin%0d", tag, i), longint'(bin_cnt),
             (i == hot_a) ? cnt_a : ((i == hot_b) ? cnt_b : 0));
      end
   endtask

   task automatic chk_done_once(input string tag);
      int extra;
      extra = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (done) extra++;
      end
      chk({tag, "_extra_done"}, extra, 0);
   endtask

   initial begin
      int lat;
      int bcnt;
      int dcnt;
      n_cmp   = 0;
      n_bad   = 0;
      gap_err = 0;
      reset   = 1'b1;
      start   = 1'b1;
      bin_sel = 4'd0;
      fill(0, 8'h5A);

      // Reset with start held high: must stay idle
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_min", min_val, 255);
      chk("rst_max", max_val, 0);
      chk("rst_sum", sum_val, 0);
      chk("rst_mean", mean_val, 0);
      chk_bins("rst", 0, 0, 0, 0);

      // Uniform 8'h5A
      scan(-1, -1, lat, bcnt);
      chk("u5a_latency", lat, 16386);
      chk("u5a_busy_cycles", bcnt, 16385);
      chk("u5a_busy_at_done", busy, 0);
      chk("u5a_min", min_val, 90);
      chk("u5a_max", max_val, 90);
      chk("u5a_mean", mean_val, 90);
      chk("u5a_sum", sum_val, 1474560);
      chk_bins("u5a", 5, 16384, -1, 0);
      chk_done_once("u5a");
      chk("u5a_hold_sum", sum_val, 1474560);

      // All 8'hFF with stray starts in cycles 100 and 16385
      fill(0, 8'hFF);
      scan(100, 16385, lat, bcnt);
      chk("uff_latency", lat, 16386);
      chk("uff_busy_cycles", bcnt, 16385);
      chk("uff_sum", sum_val, 4177920);
      chk("uff_mean", mean_val, 255);
      chk("uff_min", min_val, 255);
      chk("uff_max", max_val, 255);
      chk_bins("uff", 15, 16384, -1, 0);
      chk_done_once("uff");

      // Ramp: second scan after FF must start from cleared stats
      fill(1, 8'h00);
      gap_err = 0;
      scan(-1, -1, lat, bcnt);
      chk("ramp_latency", lat, 16386);
      chk("ramp_raddr_seq_errors", gap_err, 0);
      chk("ramp_min", min_val, 0);
      chk("ramp_max", max_val, 255);
      chk("ramp_sum", sum_val, 2088960);
      chk("ramp_mean", mean_val, 127);
      for (int i = 0; i < 16; i++) begin
         bin_sel = 4'(i);
         #1;
         chk($sformatf("ramp_bin%0d", i), longint'(bin_cnt), 1024);
      end
      chk_done_once("ramp");

      // Split image, reset asserted in cycle 8000 of the scan
      fill(2, 8'h00);
      bin_sel = 4'd2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7999) @(posedge clk);
      #1;
      chk("abort_busy_before", busy, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_raddr", raddr, 0);
      chk("abort_min", min_val, 255);
      chk("abort_max", max_val, 0);
      chk("abort_sum", sum_val, 0);
      chk("abort_bin2", bin_cnt, 0);
      dcnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);

      // Split image completes normally after the abort
      scan(-1, -1, lat, bcnt);
      chk("split_latency", lat, 16386);
      chk("split_min", min_val, 35);
      chk("split_max", max_val, 199);
      chk("split_sum", sum_val, 1916928);
      chk("split_mean", mean_val, 117);
      chk_bins("split", 2, 8192, 12, 8192);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
